// File: rtl/q_tile_loader.sv
// rtl/q_tile_loader.sv - fetches Q-vector tiles as narrow beats and pushes assembled rows
// Assembly and output registers are double-buffered so row r+1 fetches while row r pushes.
`ifndef NUM_PES
`define NUM_PES 4
`endif

module q_tile_loader #(
  parameter int NUM_ROWS   = `NUM_PES,
  parameter int EMBED_DIM  = 64,
  parameter int ELEM_W     = 8,
  parameter int BEAT_ELEMS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [ADDR_W-1:0]              base_addr_i,
  input  logic [7:0]                     num_tiles_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [ADDR_W-1:0]              mem_req_addr_o,
  input  logic                           mem_rsp_valid_i,
  output logic                           mem_rsp_ready_o,
  input  logic [BEAT_ELEMS*ELEM_W-1:0]   mem_rsp_data_i,
  output logic                           write_enable_o,
  input  logic                           sram_ready_i,
  output logic [EMBED_DIM*ELEM_W-1:0]    write_data_o
);

  localparam int BEATS      = EMBED_DIM / BEAT_ELEMS;
  localparam int BEAT_BYTES = BEAT_ELEMS * ELEM_W / 8;
  localparam int BEAT_W     = BEAT_ELEMS * ELEM_W;
  localparam int ROW_W      = EMBED_DIM * ELEM_W;
  localparam int CNT_W      = 8 + $clog2(NUM_ROWS * BEATS + 1);
  localparam int CRD_W      = $clog2(BEATS + 1);
  localparam int BIDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]  TILE_BEATS = CNT_W'(NUM_ROWS * BEATS);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CRD_W-1:0]  CRD_MAX    = CRD_W'(BEATS);
  localparam logic [BIDX_W-1:0] LAST_BEAT  = BIDX_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BEAT_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [CNT_W-1:0]    req_left_q, req_left_d;
  logic [CNT_W-1:0]    rsp_left_q, rsp_left_d;
  logic [CRD_W-1:0]    credit_q, credit_d;
  logic [BIDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [ROW_W-1:0]    asm_q, asm_d;
  logic                asm_full_q, asm_full_d;
  logic [ROW_W-1:0]    out_q, out_d;
  logic                out_full_q, out_full_d;
  logic                done_q, done_d;

  logic                req_valid, rsp_ready, req_fire, rsp_fire, push;
  logic [ROW_W-1:0]    asm_merged;

  assign req_valid = (state_q == S_RUN) && (req_left_q != '0) && (credit_q < CRD_MAX);
  assign rsp_ready = (state_q == S_RUN) && !asm_full_q;
  assign req_fire  = req_valid && mem_req_ready_i;
  assign rsp_fire  = rsp_ready && mem_rsp_valid_i;
  assign push      = out_full_q && sram_ready_i;

  always_comb begin
    asm_merged = asm_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_idx_q == BIDX_W'(b)) asm_merged[b*BEAT_W +: BEAT_W] = mem_rsp_data_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_left_d = req_left_q;
    rsp_left_d = rsp_left_q;
    credit_d   = credit_q + CRD_W'(req_fire) - CRD_W'(rsp_fire);
    beat_idx_d = beat_idx_q;
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    out_d      = out_q;
    out_full_d = out_full_q;
    done_d     = 1'b0;

    if (push) out_full_d = 1'b0;

    // A parked row moves up as soon as the output register frees.
    if (asm_full_q && (!out_full_q || push)) begin
      out_d      = asm_q;
      out_full_d = 1'b1;
      asm_full_d = 1'b0;
    end

    if (req_fire) begin
      req_addr_d = req_addr_q + ADDR_STEP;
      req_left_d = req_left_q - CNT_ONE;
    end

    if (rsp_fire) begin
      asm_d      = asm_merged;
      rsp_left_d = rsp_left_q - CNT_ONE;
      if (beat_idx_q == LAST_BEAT) begin
        beat_idx_d = '0;
        if (!out_full_q || push) begin
          out_d      = asm_merged;
          out_full_d = 1'b1;
        end else begin
          asm_full_d = 1'b1;
        end
      end else begin
        beat_idx_d = beat_idx_q + BIDX_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (num_tiles_i != 8'd0) begin
            state_d    = S_RUN;
            req_addr_d = base_addr_i;
            req_left_d = CNT_W'(num_tiles_i) * TILE_BEATS;
            rsp_left_d = CNT_W'(num_tiles_i) * TILE_BEATS;
            credit_d   = '0;
            beat_idx_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (rsp_fire && (rsp_left_q == CNT_ONE)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Final push is the one with nothing left parked behind it.
        if (push && !asm_full_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_left_q <= '0;
      rsp_left_q <= '0;
      credit_q   <= '0;
      beat_idx_q <= '0;
      asm_q      <= '0;
      asm_full_q <= 1'b0;
      out_q      <= '0;
      out_full_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_left_q <= req_left_d;
      rsp_left_q <= rsp_left_d;
      credit_q   <= credit_d;
      beat_idx_q <= beat_idx_d;
      asm_q      <= asm_d;
      asm_full_q <= asm_full_d;
      out_q      <= out_d;
      out_full_q <= out_full_d;
      done_q     <= done_d;
    end
  end

  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done_q;
  assign mem_req_valid_o = req_valid;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_rsp_ready_o = rsp_ready;
  assign write_enable_o  = out_full_q;
  assign write_data_o    = out_q;

endmodule
